neuron_mac: RTL

- Sequential multiply-accumulate neuron that computes one fixed-point dot product plus bias and feeds the downstream ReLU stage.
- Consumes N_INPUTS activation/weight pairs over a valid/ready stream and rescales the sum to the activation format.
- Emits a registered result with a one-cycle `mac_done` pulse, which wires directly to the ReLU `go` input, with `data_out` wired to its `data_in`.

---
 rtl/neuron_mac.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/neuron_mac.sv
// ============================================================================
// Module      : neuron_mac
// Description : Sequential multiply-accumulate neuron. Computes one
//               fixed-point dot product of N_INPUTS activation/weight pairs
//               plus a bias, rescales it to the activation Q format and
//               presents it with a one-cycle mac_done pulse. The pulse feeds
//               the ReLU stage's go input, and data_out feeds its data_in.
// Options     : MAC_SATURATE_EN - when defined, the rescaled result is clamped
//               to the signed ACC_WIDTH range; otherwise the low ACC_WIDTH
//               bits are kept (two's-complement wrap).
// Ports       : clk       - system clock, rising edge
//               reset     - synchronous active-high reset
//               mac_go    - start pulse, honoured only when idle
//               bias      - signed bias (Q.FRAC_BITS), captured with mac_go
//               in_valid  - operand pair valid
//               in_data   - signed activation
//               weight    - signed weight
//               in_ready  - operand pair accepted when in_valid && in_ready
//               busy      - operation in progress
//               data_out  - signed result, held until the next result
//               mac_done  - one-cycle pulse, data_out valid in same cycle
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module neuron_mac #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int N_INPUTS   = 784,
    parameter int FRAC_BITS  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mac_go,
    input  logic [ACC_WIDTH-1:0]  bias,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [DATA_WIDTH-1:0] weight,
    output logic                  in_ready,
    output logic                  busy,
    output logic [ACC_WIDTH-1:0]  data_out,
    output logic                  mac_done
);

    // Accumulator is wide enough for every product sum and for the bias
    // pre-shifted into the product Q format, so it can never overflow.
    localparam int PROD_W    = 2 * DATA_WIDTH;
    localparam int SUM_W     = PROD_W + $clog2(N_INPUTS) + 1;
    localparam int BIAS_W    = ACC_WIDTH + FRAC_BITS + 1;
    localparam int ACC_INT_W = (SUM_W > BIAS_W) ? SUM_W : BIAS_W;
    localparam int CNT_W     = $clog2(N_INPUTS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_FINAL = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic signed [ACC_INT_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0]          data_out_q, data_out_d;
    logic                          done_q, done_d;

    logic signed [PROD_W-1:0]      w_prod;
    logic signed [ACC_INT_W-1:0]   w_prod_ext;
    logic signed [ACC_INT_W-1:0]   w_bias_ext;
    logic signed [ACC_INT_W-1:0]   w_shifted;
    logic [ACC_WIDTH-1:0]          w_narrow;
    logic                          w_beat;

    assign w_prod     = $signed(in_data) * $signed(weight);
    assign w_prod_ext = {{(ACC_INT_W - PROD_W){w_prod[PROD_W-1]}}, w_prod};
    // Bias is in result Q format; products carry 2*FRAC_BITS fraction bits.
    assign w_bias_ext = $signed({{(ACC_INT_W - ACC_WIDTH){bias[ACC_WIDTH-1]}}, bias})
                        <<< FRAC_BITS;
    // Arithmetic shift rounds toward negative infinity.
    assign w_shifted  = acc_q >>> FRAC_BITS;

`ifdef MAC_SATURATE_EN
    localparam logic signed [ACC_INT_W-1:0] C_SAT_MAX =
        ACC_INT_W'({1'b0, {(ACC_WIDTH - 1){1'b1}}});
    localparam logic signed [ACC_INT_W-1:0] C_SAT_MIN = ~C_SAT_MAX;

    always_comb begin
        if (w_shifted > C_SAT_MAX) begin
            w_narrow = C_SAT_MAX[ACC_WIDTH-1:0];
        end else if (w_shifted < C_SAT_MIN) begin
            w_narrow = C_SAT_MIN[ACC_WIDTH-1:0];
        end else begin
            w_narrow = w_shifted[ACC_WIDTH-1:0];
        end
    end
`else
    assign w_narrow = ACC_WIDTH'(w_shifted);
`endif

    assign in_ready = (state_q == S_ACCUM);
    assign busy     = (state_q != S_IDLE);
    assign w_beat   = in_valid && in_ready;
    assign data_out = data_out_q;
    assign mac_done = done_q;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        data_out_d = data_out_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mac_go) begin
                    acc_d   = w_bias_ext;
                    cnt_d   = '0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_beat) begin
                    acc_d = acc_q + w_prod_ext;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N_INPUTS - 1)) begin
                        state_d = S_FINAL;
                    end
                end
            end
            S_FINAL: begin
                data_out_d = w_narrow;
                done_d     = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            data_out_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
        end
    end

endmodule

`default_nettype wire
